// File: rtl/jogo_pkg.sv
// ----------------------------------------------------------------------------
// jogo_pkg
// Shared constants for the memory-sequence game control unit.
//   - 4-bit state codes. The state register holds these values directly, so
//     the debug output db_estado simply mirrors the state register.
//   - Debug code that is shown when the state register holds an unused value.
//   - Default number of clock cycles allowed per move before a timeout.
// ----------------------------------------------------------------------------
package jogo_pkg;

    localparam logic [3:0] S_INICIAL     = 4'h0;
    localparam logic [3:0] S_PREPARACAO  = 4'h1;
    localparam logic [3:0] S_ESPERA      = 4'h2;
    localparam logic [3:0] S_REGISTRA    = 4'h4;
    localparam logic [3:0] S_COMPARACAO  = 4'h5;
    localparam logic [3:0] S_PROXIMO     = 4'h6;
    localparam logic [3:0] S_FIM_ACERTO  = 4'hA;
    localparam logic [3:0] S_FIM_TIMEOUT = 4'hC;
    localparam logic [3:0] S_FIM_ERRO    = 4'hE;

    // Shown on db_estado when the state register holds an unused code
    localparam logic [3:0] DB_ILEGAL     = 4'hF;

    // Default number of cycles allowed per move
    localparam int TIMEOUT_CYCLES_DEF    = 5000;

endpackage

// File: rtl/jogo_sequencia_uc_edge_detector.sv
// ----------------------------------------------------------------------------
// edge_detector
// Rising-edge detector for an already-synchronized level signal.
// Ports:
//   clock  in  system clock (rising edge)
//   reset  in  asynchronous active-high reset, clears the delay flop
//   sinal  in  synchronized level
//   pulso  out one-cycle high when sinal is 1 and was 0 on the previous cycle
// A level that is already high when reset is released produces a pulse on
// the first cycle, because the delay flop resets to 0.
// ----------------------------------------------------------------------------
module edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic sinal,
    output logic pulso
);

    logic sinal_d_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinal_d_reg <= 1'b0;
        end else begin
            sinal_d_reg <= sinal;
        end
    end

    assign pulso = sinal & ~sinal_d_reg;

endmodule

// File: rtl/jogo_sequencia_uc.sv
// ----------------------------------------------------------------------------
// jogo_sequencia_uc
// Moore control unit for the memory-sequence game. It waits for each player
// move (rising edge of jogada), has the datapath register the switches,
// checks the comparator result and advances the address counter. The game
// ends with a win, a wrong move or (optionally) a per-move timeout.
//
// Build option: define JOGO_TIMEOUT_EN to generate the per-move timeout
// counter, the FIM_TIMEOUT state and the timeout output. Without it ESPERA
// waits indefinitely, timeout is tied to 0 and TIMEOUT_CYCLES is unused.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles allowed per move in ESPERA (>= 2)
//   TW              width of the timeout counter
// Ports:
//   clock      in   system clock (rising edge)
//   reset      in   asynchronous active-high reset -> INICIAL
//   iniciar    in   starts / restarts a game (level)
//   jogada     in   synchronized button level, rising edge is a move
//   fimC       in   datapath address counter at last address
//   igual      in   datapath comparator match
//   zeraC      out  clear address counter
//   contaC     out  increment address counter
//   zeraR      out  clear switch register
//   registraR  out  load switch register
//   pronto     out  game finished
//   acertou    out  finished with all moves correct
//   errou      out  finished by wrong move or timeout
//   timeout    out  finished by timeout
//   db_estado  out  debug state code
// ----------------------------------------------------------------------------
module jogo_sequencia_uc
    import jogo_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int TW             = $clog2(TIMEOUT_CYCLES)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       fimC,
    input  logic       igual,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    // Elaboration-time sanity check on the timeout configuration
    if (TIMEOUT_CYCLES < 2 || TW < 1) begin : g_param_check
        $error("jogo_sequencia_uc: TIMEOUT_CYCLES must be >= 2");
    end

    logic [3:0] estado_reg;
    logic [3:0] estado_next;
    logic       jog_pulse;

    // A button already held when ESPERA is entered gives no pulse, since the
    // delay flop tracks jogada every cycle regardless of state.
    edge_detector u_edge_jogada (
        .clock (clock),
        .reset (reset),
        .sinal (jogada),
        .pulso (jog_pulse)
    );

`ifdef JOGO_TIMEOUT_EN
    // Per-move timer: counts only while in ESPERA, held at 0 elsewhere, so
    // every entry into ESPERA starts a fresh count from 0.
    logic [TW-1:0] tmr_reg;
    logic          tmr_fim;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmr_reg <= '0;
        end else if (estado_reg == S_ESPERA) begin
            tmr_reg <= tmr_reg + 1'b1;
        end else begin
            tmr_reg <= '0;
        end
    end

    assign tmr_fim = (tmr_reg == TW'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_reg <= S_INICIAL;
        end else begin
            estado_reg <= estado_next;
        end
    end

    always_comb begin
        estado_next = S_INICIAL;
        case (estado_reg)
            S_INICIAL:    estado_next = iniciar ? S_PREPARACAO : S_INICIAL;
            S_PREPARACAO: estado_next = S_ESPERA;
            S_ESPERA: begin
                // A move arriving on the last timer cycle still counts
                if (jog_pulse) begin
                    estado_next = S_REGISTRA;
`ifdef JOGO_TIMEOUT_EN
                end else if (tmr_fim) begin
                    estado_next = S_FIM_TIMEOUT;
`endif
                end else begin
                    estado_next = S_ESPERA;
                end
            end
            S_REGISTRA:   estado_next = S_COMPARACAO;
            S_COMPARACAO: begin
                if (!igual) begin
                    estado_next = S_FIM_ERRO;
                end else if (fimC) begin
                    estado_next = S_FIM_ACERTO;
                end else begin
                    estado_next = S_PROXIMO;
                end
            end
            S_PROXIMO:    estado_next = S_ESPERA;
`ifdef JOGO_TIMEOUT_EN
            S_FIM_TIMEOUT,
`endif
            S_FIM_ACERTO,
            S_FIM_ERRO:   estado_next = iniciar ? S_PREPARACAO : estado_reg;
            default:      estado_next = S_INICIAL;
        endcase
    end

    // Moore output decode: depends on the state register only
    always_comb begin
        zeraC     = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        contaC    = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        db_estado = estado_reg;
        case (estado_reg)
            S_INICIAL, S_PREPARACAO: begin
                zeraC = 1'b1;
                zeraR = 1'b1;
            end
            S_ESPERA, S_COMPARACAO: ;
            S_REGISTRA:   registraR = 1'b1;
            S_PROXIMO:    contaC    = 1'b1;
            S_FIM_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            S_FIM_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
`ifdef JOGO_TIMEOUT_EN
            S_FIM_TIMEOUT: begin
                pronto  = 1'b1;
                errou   = 1'b1;
                timeout = 1'b1;
            end
`endif
            default:      db_estado = DB_ILEGAL;
        endcase
    end

endmodule
